tis_any_port_arbiter: RTL and testbench



---
 rtl/tis_pkg.sv | 39 +++
 rtl/tis_port_prio_pick.sv | 27 ++
 rtl/tis_any_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_tis_any_port_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tis_pkg.sv
// Shared constants for the tis100 node port arbiter: link field layout,
// port codes, FSM state encodings and a port-code to one-hot helper.
package tis_pkg;

    localparam int DATA_W       = 11;
    localparam int LINK_W       = 15;
    localparam int DATA_LSB     = 0;
    localparam int DATA_MSB     = 10;
    localparam int WR_VALID_BIT = 11;
    localparam int RD_REQ_BIT   = 12;
    localparam int ACK_BIT      = 13;

    localparam logic [2:0] PORT_NONE  = 3'd0;
    localparam logic [2:0] PORT_LEFT  = 3'd1;
    localparam logic [2:0] PORT_RIGHT = 3'd2;
    localparam logic [2:0] PORT_UP    = 3'd3;
    localparam logic [2:0] PORT_DOWN  = 3'd4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_WAIT  = 3'd1;
    localparam logic [2:0] ST_RD_ACK   = 3'd2;
    localparam logic [2:0] ST_WR_SEL   = 3'd3;
    localparam logic [2:0] ST_WR_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE_NIL = 3'd5;

    // Mask bit 0..3 = left, right, up, down.
    function automatic logic [3:0] port_mask(input logic [2:0] code);
        logic [3:0] mask;
        case (code)
            PORT_LEFT:  mask = 4'b0001;
            PORT_RIGHT: mask = 4'b0010;
            PORT_UP:    mask = 4'b0100;
            PORT_DOWN:  mask = 4'b1000;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tis_port_prio_pick.sv
// Combinational priority picker: first set request scanning L,R,U,D from a
// start index (wrapping), returned as one-hot grant and port code.
module tis_port_prio_pick (
    input  logic [3:0] req_i,
    input  logic [1:0] start_i,
    output logic [3:0] gnt_o,
    output logic [2:0] port_o
);
    import tis_pkg::*;

    logic [1:0] idx;

    // Walk from lowest to highest priority so the highest priority hit wins last.
    always_comb begin
        gnt_o  = 4'b0000;
        port_o = PORT_NONE;
        idx    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = start_i + 2'(i);
            if (req_i[idx]) begin
                gnt_o  = 4'b0001 << idx;
                port_o = {1'b0, idx} + 3'd1;
            end
        end
    end

endmodule

// File: rtl/tis_any_port_arbiter.sv
// Port arbiter for one tis100 node: sequences ANY/LAST reads and writes over the
// four neighbour links. Define TIS_ANY_ROUND_ROBIN_EN for round-robin ANY scan.
module tis_any_port_arbiter #(
    parameter int DATA_W     = 11,
    parameter int PRIO_ORDER = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_read_any,
    input  logic              op_read_last,
    input  logic              op_write_any,
    input  logic              op_write_last,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              op_done,
    output logic [DATA_W-1:0] rd_data,
    output logic [2:0]        last_port,
    input  logic [14:0]       left,
    input  logic [14:0]       right,
    input  logic [14:0]       up,
    input  logic [14:0]       down,
    output logic [14:0]       leftOut,
    output logic [14:0]       rightOut,
    output logic [14:0]       upOut,
    output logic [14:0]       downOut
);
    import tis_pkg::*;

    logic [LINK_W-1:0] in_bus  [4];
    logic [LINK_W-1:0] out_bus [4];
    logic [3:0]        in_wr_valid, in_rd_req, in_ack;

    logic [2:0]        state_q, state_d;
    logic              op_any_q, op_any_d;
    logic [3:0]        win_q, win_d;
    logic [2:0]        win_port_q, win_port_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [2:0]        last_port_q, last_port_d;

    logic [3:0]        cand;
    logic [3:0]        pick_req, pick_gnt;
    logic [2:0]        pick_port;
    logic [1:0]        pick_start;

    assign in_bus[0] = left;
    assign in_bus[1] = right;
    assign in_bus[2] = up;
    assign in_bus[3] = down;

    assign leftOut  = out_bus[0];
    assign rightOut = out_bus[1];
    assign upOut    = out_bus[2];
    assign downOut  = out_bus[3];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_wr_valid[i] = in_bus[i][WR_VALID_BIT];
            in_rd_req[i]   = in_bus[i][RD_REQ_BIT];
            in_ack[i]      = in_bus[i][ACK_BIT];
        end
    end

    assign cand     = op_any_q ? 4'b1111 : port_mask(last_port_q);
    assign pick_req = ((state_q == ST_WR_SEL) ? in_rd_req : in_wr_valid) & cand;

`ifdef TIS_ANY_ROUND_ROBIN_EN
    logic [1:0] rr_q, rr_d;
    assign pick_start = op_any_q ? rr_q : 2'd0;
`else
    assign pick_start = 2'd0;
`endif

    tis_port_prio_pick u_pick (
        .req_i   (pick_req),
        .start_i (pick_start),
        .gnt_o   (pick_gnt),
        .port_o  (pick_port)
    );

    always_comb begin
        state_d     = state_q;
        op_any_d    = op_any_q;
        win_d       = win_q;
        win_port_d  = win_port_q;
        wr_data_d   = wr_data_q;
        rd_data_d   = rd_data_q;
        last_port_d = last_port_q;
`ifdef TIS_ANY_ROUND_ROBIN_EN
        rr_d        = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (op_read_any) begin
                    op_any_d = 1'b1;
                    state_d  = ST_RD_WAIT;
                end else if (op_read_last) begin
                    op_any_d = 1'b0;
                    if (last_port_q == PORT_NONE) begin
                        rd_data_d = '0;
                        state_d   = ST_DONE_NIL;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end else if (op_write_any) begin
                    op_any_d  = 1'b1;
                    wr_data_d = wr_data;
                    state_d   = ST_WR_SEL;
                end else if (op_write_last) begin
                    op_any_d  = 1'b0;
                    wr_data_d = wr_data;
                    state_d   = (last_port_q == PORT_NONE) ? ST_DONE_NIL : ST_WR_SEL;
                end
            end
            ST_RD_WAIT: begin
                if (pick_port != PORT_NONE) begin
                    win_d      = pick_gnt;
                    win_port_d = pick_port;
                    for (int i = 0; i < 4; i++) begin
                        if (pick_gnt[i]) rd_data_d = in_bus[i][DATA_MSB:DATA_LSB];
                    end
                    if (op_any_q) begin
                        last_port_d = pick_port;
`ifdef TIS_ANY_ROUND_ROBIN_EN
                        rr_d = pick_port[1:0];
`endif
                    end
                    state_d = ST_RD_ACK;
                end
            end
            ST_RD_ACK: state_d = ST_IDLE;
            ST_WR_SEL: begin
                if (pick_port != PORT_NONE) begin
                    win_d      = pick_gnt;
                    win_port_d = pick_port;
                    state_d    = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if ((in_ack & win_q) != 4'b0000) begin
                    if (op_any_q) begin
                        last_port_d = win_port_q;
`ifdef TIS_ANY_ROUND_ROBIN_EN
                        // Port code low bits already index the next port in the ring.
                        rr_d = win_port_q[1:0];
`endif
                    end
                    // Write completion shares the idle-bus done cycle with NIL ops.
                    state_d = ST_DONE_NIL;
                end
            end
            ST_DONE_NIL: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_any_q    <= 1'b0;
            win_q       <= 4'b0000;
            win_port_q  <= PORT_NONE;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
            last_port_q <= PORT_NONE;
`ifdef TIS_ANY_ROUND_ROBIN_EN
            rr_q        <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            op_any_q    <= op_any_d;
            win_q       <= win_d;
            win_port_q  <= win_port_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= rd_data_d;
            last_port_q <= last_port_d;
`ifdef TIS_ANY_ROUND_ROBIN_EN
            rr_q        <= rr_d;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_bus[i] = '0;
            case (state_q)
                ST_RD_WAIT: out_bus[i][RD_REQ_BIT] = cand[i];
                ST_RD_ACK:  out_bus[i][ACK_BIT]    = win_q[i];
                ST_WR_WAIT: begin
                    if (win_q[i]) begin
                        out_bus[i][WR_VALID_BIT]      = 1'b1;
                        out_bus[i][DATA_MSB:DATA_LSB] = wr_data_q;
                    end
                end
                default: out_bus[i] = '0;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign op_done   = (state_q == ST_RD_ACK) || (state_q == ST_DONE_NIL);
    assign rd_data   = rd_data_q;
    assign last_port = last_port_q;

    logic unused_in;
    assign unused_in = ^{left[14], right[14], up[14], down[14], (PRIO_ORDER != 0), (DATA_W != 11)};

endmodule

// File: tb/tb_tis_any_port_arbiter.sv
// Directed self-checking bench for tis_any_port_arbiter; round-robin expectations
// follow TIS_ANY_ROUND_ROBIN_EN when it is defined.
module tb_tis_any_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_read_any, op_read_last, op_write_any, op_write_last;
    logic [10:0] wr_data;
    logic        busy, op_done;
    logic [10:0] rd_data;
    logic [2:0]  last_port;
    logic [14:0] left, right, up, down;
    logic [14:0] leftOut, rightOut, upOut, downOut;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [14:0] RDREQ = 15'h1000;
    localparam logic [14:0] WRV   = 15'h0800;
    localparam logic [14:0] ACK   = 15'h2000;

    always #5 clk = ~clk;

    tis_any_port_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .op_read_any   (op_read_any),
        .op_read_last  (op_read_last),
        .op_write_any  (op_write_any),
        .op_write_last (op_write_last),
        .wr_data       (wr_data),
        .busy          (busy),
        .op_done       (op_done),
        .rd_data       (rd_data),
        .last_port     (last_port),
        .left          (left),
        .right         (right),
        .up            (up),
        .down          (down),
        .leftOut       (leftOut),
        .rightOut      (rightOut),
        .upOut         (upOut),
        .downOut       (downOut)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [59:0] outs();
        return {leftOut, rightOut, upOut, downOut};
    endfunction

    initial begin
        reset = 1'b1;
        {op_read_any, op_read_last, op_write_any, op_write_last} = 4'b0000;
        wr_data = '0;
        {left, right, up, down} = '0;
        cyc(); cyc();
        reset = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", op_done, 0);
        check_eq("rst_rdata", rd_data, 0);
        check_eq("rst_last", last_port, 0);
        check_eq("rst_outs", outs(), 0);

        // LAST read with no LAST port: NIL completes the cycle after accept.
        op_read_last = 1'b1;
        cyc();
        op_read_last = 1'b0;
        check_eq("nil_done", op_done, 1);
        check_eq("nil_rdata", rd_data, 0);
        check_eq("nil_outs", outs(), 0);
        cyc();
        check_eq("nil_idle_done", op_done, 0);
        check_eq("nil_idle_busy", busy, 0);

        // ANY read, only up offers data 7.
        op_read_any = 1'b1;
        up = WRV | 15'd7;
        cyc();
        op_read_any = 1'b0;
        check_eq("rd1_req", outs(), {RDREQ, RDREQ, RDREQ, RDREQ});
        check_eq("rd1_busy", busy, 1);
        check_eq("rd1_nodone", op_done, 0);
        cyc();
        check_eq("rd1_ack", outs(), {15'h0, 15'h0, ACK, 15'h0});
        check_eq("rd1_done", op_done, 1);
        check_eq("rd1_rdata", rd_data, 7);
        check_eq("rd1_last", last_port, 3);
        up = '0;
        cyc();
        check_eq("rd1_ackdrop", outs(), 0);
        check_eq("rd1_idle", {busy, op_done}, 0);

        // ANY write 42, right requests; a read_any while busy must be ignored.
        op_write_any = 1'b1;
        wr_data = 11'd42;
        right = RDREQ;
        cyc();
        op_write_any = 1'b0;
        op_read_any = 1'b1;
        check_eq("wr1_sel_outs", outs(), 0);
        check_eq("wr1_sel_busy", busy, 1);
        cyc();
        check_eq("wr1_drive", outs(), {15'h0, WRV | 15'd42, 15'h0, 15'h0});
        check_eq("wr1_nodone", op_done, 0);
        right = ACK;
        cyc();
        op_read_any = 1'b0;
        check_eq("wr1_drop", outs(), 0);
        check_eq("wr1_done", {busy, op_done}, 2'b11);
        check_eq("wr1_last", last_port, 2);
        right = '0;
        cyc();
        check_eq("wr1_idle", {busy, op_done}, 0);
        cyc();
        check_eq("busy_ignored", {busy, op_done}, 0);

        // LAST write -1 goes to right only even though up also requests.
        op_write_last = 1'b1;
        wr_data = 11'h7FF;
        right = RDREQ;
        up = RDREQ;
        cyc();
        op_write_last = 1'b0;
        cyc();
        check_eq("wr2_drive", outs(), {15'h0, WRV | 15'h7FF, 15'h0, 15'h0});
        right = ACK;
        cyc();
        check_eq("wr2_done", op_done, 1);
        check_eq("wr2_last", last_port, 2);
        right = '0;
        up = '0;
        cyc();

        // Reset in WR_WAIT aborts with no completion.
        op_write_last = 1'b1;
        wr_data = 11'd9;
        right = RDREQ;
        cyc();
        op_write_last = 1'b0;
        cyc();
        check_eq("wr3_drive", outs(), {15'h0, WRV | 15'd9, 15'h0, 15'h0});
        reset = 1'b1;
        cyc();
        check_eq("abort_outs", outs(), 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_last", last_port, 0);
        check_eq("abort_done", op_done, 0);
        reset = 1'b0;
        right = '0;
        cyc();
        check_eq("abort_after", {busy, op_done}, 0);

        // Simultaneous left=5 and down=-3.
        op_read_any = 1'b1;
        left = WRV | 15'd5;
        down = WRV | 15'h7FD;
        cyc();
        op_read_any = 1'b0;
        cyc();
        check_eq("rd2_ack", outs(), {ACK, 15'h0, 15'h0, 15'h0});
        check_eq("rd2_rdata", rd_data, 5);
        check_eq("rd2_last", last_port, 1);
        cyc();
        op_read_any = 1'b1;
        cyc();
        op_read_any = 1'b0;
        check_eq("rd3_req", downOut, RDREQ);
        cyc();
        check_eq("rd3_done", op_done, 1);
`ifdef TIS_ANY_ROUND_ROBIN_EN
        check_eq("rd3_ack", outs(), {15'h0, 15'h0, 15'h0, ACK});
        check_eq("rd3_rdata", rd_data, 11'h7FD);
        check_eq("rd3_last", last_port, 4);
`else
        check_eq("rd3_ack", outs(), {ACK, 15'h0, 15'h0, 15'h0});
        check_eq("rd3_rdata", rd_data, 5);
        check_eq("rd3_last", last_port, 1);
`endif
        left = '0;
        down = '0;
        cyc();
        check_eq("rd3_idle", {busy, op_done}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
